// File: rtl/sm3_cfg_pkg.sv
// sm3_cfg: shared configuration for the SM3 datapath blocks.
//
// Holds the default requester count for the adder arbiter, the depth of its
// result FIFO, the 32-bit word type and the helper that derives the requester
// index width from the requester count.
//
// Global define SM3_ADDER_CSA selects the carry-save form of sm3_adder.

package sm3_cfg;

  localparam int SM3_NUM_REQ    = 4;
  localparam int SM3_FIFO_DEPTH = 2;

  typedef logic [31:0] word_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int sm3_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sm3_adder.sv
// sm3_adder: three-operand 32-bit adder, sum = a + b + c mod 2^32.
//
// Ports:
//   a, b, c : input  32-bit operands
//   sum     : output 32-bit modular sum (purely combinational)
//
// With SM3_ADDER_CSA defined the operands are first compressed by a
// carry-save stage and then resolved by a single carry-propagate add;
// otherwise two chained additions are used. Both forms give identical results.

module sm3_adder
  import sm3_cfg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  output word_t sum
);

`ifdef SM3_ADDER_CSA
  word_t              save_vec;
  logic [30:0]        carry_low;

  assign save_vec  = a ^ b ^ c;
  // Only bits 30:0 of the majority vector matter; bit 31 would shift out.
  assign carry_low = (a[30:0] & b[30:0]) | (a[30:0] & c[30:0]) | (b[30:0] & c[30:0]);
  assign sum       = save_vec + {carry_low, 1'b0};
`else
  assign sum = a + b + c;
`endif

endmodule

// File: rtl/sm3_adder_arb.sv
// sm3_adder_arb: round-robin arbiter sharing one sm3_adder among NUM_REQ
// requesters, with a 2-entry in-order result FIFO of {id, sum}.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   req_valid[N]      : requester i presents operands
//   req_a/b/c[32*N]   : operands, requester i in bits [32i+31:32i]
//   req_ready[N]      : one-hot (or zero) grant, operands consumed this cycle
//   res_valid         : FIFO head holds a result
//   res_ready         : downstream accepts the head
//   res_data          : head sum
//   res_id            : head requester index
//   busy              : any request pending or any result buffered

module sm3_adder_arb
  import sm3_cfg::*;
#(
  parameter int NUM_REQ = SM3_NUM_REQ,
  parameter int ID_W    = sm3_id_w(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [32*NUM_REQ-1:0]  req_c,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  localparam int              DEPTH      = SM3_FIFO_DEPTH;
  localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] last_grant;
  logic [1:0]      count;
  logic            rd_ptr;
  logic            wr_ptr;
  word_t           fifo_sum [DEPTH];
  logic [ID_W-1:0] fifo_id  [DEPTH];

  logic [ID_W:0]   pick;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            full;
  logic            can_accept;
  logic            push;
  logic            pop;
  word_t           sel_a;
  word_t           sel_b;
  word_t           sel_c;
  word_t           sum;

  // Search starts just after the previous winner, so each requester is at
  // most NUM_REQ-1 positions away from the head of the search.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] result;
    int            idx;
    result = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!result[ID_W] && valid[idx]) begin
        result = {1'b1, ID_W'(idx)};
      end
    end
    return result;
  endfunction

  assign pick        = rr_pick(req_valid, last_grant);
  assign grant_found = pick[ID_W];
  assign grant_idx   = pick[ID_W-1:0];

  // A full FIFO can still take a request when the head leaves this cycle.
  assign full       = (count == 2'(DEPTH));
  assign can_accept = !full || res_ready;
  assign push       = grant_found && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push && (grant_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
        sel_c = req_c[32*i +: 32];
      end
    end
  end

  sm3_adder u_adder (
    .a   (sel_a),
    .b   (sel_b),
    .c   (sel_c),
    .sum (sum)
  );

  // Outputs are forced quiet while reset is asserted.
  assign res_valid = (count != 2'd0) && !rst;
  assign res_data  = rst ? '0 : fifo_sum[rd_ptr];
  assign res_id    = rst ? '0 : fifo_id[rd_ptr];
  assign busy      = (|req_valid) || res_valid;
  assign pop       = res_valid && res_ready;

  // Two-entry FIFO: the 1-bit pointers simply toggle. On a push while full
  // the write slot equals the slot being popped, which is safe because the
  // head has already been presented combinationally this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      last_grant <= LAST_RESET;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_sum[i] <= '0;
        fifo_id[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_sum[wr_ptr] <= sum;
        fifo_id[wr_ptr]  <= grant_idx;
        wr_ptr           <= ~wr_ptr;
        last_grant       <= grant_idx;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

endmodule

// File: doc/sm3_adder_arb.md
SM3_ADDER_ARB -- requirements
Module: sm3_adder_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sm3_adder; legal range 2..8.
REQ-002 Parameter ID_W, default 2: width of the requester index, equal to clog2(NUM_REQ).
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset; synchronous and active-high.
REQ-005 Port req_valid, input, NUM_REQ: bit i means requester i presents operands.
REQ-006 Port req_a, input, 32*NUM_REQ: operand A; requester i occupies bits [32i+31:32i].
REQ-007 Port req_b, input, 32*NUM_REQ: operand B, packed like req_a.
REQ-008 Port req_c, input, 32*NUM_REQ: operand C, packed like req_a.
REQ-009 Port req_ready, output, NUM_REQ: one-hot or zero grant; bit i high means requester i's operands are consumed this cycle.
REQ-010 Port res_valid, output, 1: the result at the output FIFO head is valid.
REQ-011 Port res_ready, input, 1: downstream accepts the head result.
REQ-012 Port res_data, output, 32: the sum A+B+C mod 2^32.
REQ-013 Port res_id, output, ID_W: index of the requester that produced res_data.
REQ-014 Port busy, output, 1: high while any req_valid bit is set or the FIFO is non-empty.

Function
REQ-015 A single sm3_adder instance shall compute every sum; at most one request is consumed per cycle.
REQ-016 The block shall buffer results in a 2-entry in-order FIFO holding {id, sum}, with count in the range 0..2.
REQ-017 The block can accept a request when count<2, or when count==2 and res_ready is high in the same cycle.
REQ-018 Arbitration is round-robin:
- The search starts at (last_grant+1) mod NUM_REQ.
- The first index with req_valid set wins.
- After reset the search starts at index 0.
REQ-019 req_ready[i] shall be high only when requester i wins arbitration and the block can accept; it is combinational from req_valid, the pointer and the FIFO state.
REQ-020 last_grant shall update only in a cycle where some req_ready bit is high.
REQ-021 On a grant, the sum of the winner's operands and its index shall be written into the FIFO on that clock edge.
- res_valid rises the next cycle when the FIFO was empty, giving a latency of 1 cycle.
REQ-022 Arithmetic is 32-bit modulo 2^32; carries out of bit 31 are discarded.
REQ-023 A pop occurs when res_valid and res_ready are both high.
- Simultaneous push and pop at count==1 or count==2 leaves count unchanged and preserves order.
REQ-024 A pop with res_ready high while count==0 is a no-op.
REQ-025 res_data and res_id shall be held stable while res_valid is high and res_ready is low.
REQ-026 A requester dropping req_valid before being granted is legal; no state shall change for it.
REQ-027 A requester that holds req_valid shall be granted within NUM_REQ accepting cycles (starvation-free).
REQ-028 Results shall leave the block in grant order.

Reset
REQ-029 When rst is high at a clock edge:
- count becomes 0 and both FIFO entries are invalidated.
- last_grant becomes NUM_REQ-1.
REQ-030 While rst is high: req_ready=0, res_valid=0, res_data=0, res_id=0, busy reflects req_valid only.
REQ-031 Reset asserted mid-operation shall discard buffered results without emitting them; the first post-reset grant goes to the lowest valid index.

Structure
REQ-032 The adder is the existing sm3_adder sub-module, instantiated once; its CSA/two-stage choice stays under the global configuration define.
REQ-033 The default NUM_REQ, FIFO depth (2) and ID_W derivation shall live in the shared sm3_cfg configuration file; no other package is required.
REQ-034 The round-robin pick shall be a small function or generate loop local to the module; no further sub-module.

Verification
REQ-035 Single request:
- Stimulus: requester 2 with A=0x00000001, B=0x00000002, C=0x00000003, res_ready=1.
- Required: req_ready=0b0100 in cycle 0; res_valid=1, res_data=0x00000006, res_id=2 in cycle 1.
REQ-036 Wrap-around:
- Stimulus: A=0xFFFFFFFF, B=0x00000001, C=0x00000001.
- Required: res_data=0x00000001.
REQ-037 Fairness:
- Stimulus: all 4 requesters valid continuously, res_ready=1.
- Required: grant order 0,1,2,3,0,1, one per cycle; res_id follows the same order with 1-cycle lag.
REQ-038 Backpressure:
- Stimulus: res_ready=0, requesters 0 and 1 valid.
- Required: two grants, then req_ready=0 with busy=1.
- Stimulus: raise res_ready with requester 3 valid.
- Required: res_id 0,1,3 in order; requester 3 is granted in the same cycle as the first pop.
REQ-039 Reset mid-stream:
- Stimulus: 2 results buffered, pulse rst for 1 cycle.
- Required: res_valid=0 the next cycle; next grant goes to the lowest valid index; no stale results appear.
REQ-040 Withdrawal:
- Stimulus: requester 1 drops req_valid while requester 0 is granted.
- Required: no grant to 1 and no spurious result.
